shift_serializer_ctrl: RTL and testbench
========================================

// Module: shift_serializer_ctrl
// PURPOSE
// - Sequencer for a 16-bit left-shift register: accepts a parallel word via valid/ready, then streams it MSB-first, one bit per accepted beat.
// - Owns the load/shift decisions (FSM + bit counter) and a hold-capable copy of the shift register, so the serial consumer can apply backpressure.
// - Sits between a parallel word producer and a serial sink (line encoder, SPI-style shifter).
// PARAMETERS
// - MSB    16  data word width in bits (>= 2)
// - LEN_W  5   width of i_len; must equal $clog2(MSB)+1
// PORTS
// - i_clk        in   1      clock; all state updates on posedge
// - i_rst        in   1      synchronous reset, active-high
// - din          in   MSB    parallel word to serialize
// - din_valid    in   1      din is valid
// - din_ready    out  1      block can accept a word (high only in IDLE)
// - i_len        in   LEN_W  bits to send, sampled with din; 0 or >MSB means MSB
// - i_flush      in   1      synchronous abort of the word in flight
// - o_bit        out  1      current serial bit = shift_reg[MSB-1]
// - o_bit_valid  out  1      o_bit is valid
// - i_bit_ready  in   1      sink accepts o_bit this cycle
// - o_busy       out  1      high in SHIFT and DONE
// - o_done       out  1      one-cycle pulse after the last bit is accepted
// BEHAVIOUR
// - Reset (i_rst=1 at posedge): state=IDLE, shift_reg=0, cnt=0. After the edge: din_ready=1; o_bit=0; o_bit_valid=0; o_busy=0; o_done=0.
// - i_rst has priority over i_flush and every handshake.
// - IDLE: din_ready=1. On din_valid: shift_reg<=din; cnt<=eff_len; go to SHIFT.
//   - eff_len = (i_len==0 || i_len>MSB) ? MSB : i_len.
// - SHIFT: o_bit_valid=1; din_ready=0; din_valid is ignored.
//   - Beat = o_bit_valid && i_bit_ready. On a beat: shift_reg<={shift_reg[MSB-2:0],1'b0}; cnt<=cnt-1.
//   - Beat with cnt==1: go to DONE.
//   - No beat: shift_reg, cnt and o_bit hold. o_bit stays stable while valid and not ready.
// - DONE: o_done=1 for exactly one cycle; o_bit_valid=0; din_ready=0; next state IDLE.
// - i_flush (when not in reset):
//   - In SHIFT or DONE: next state IDLE; shift_reg<=0; cnt<=0; no o_done pulse. A beat in the same cycle is consumed but discarded.
//   - In IDLE: blocks acceptance that cycle (din_ready is forced low).
// - Latency:
//   - First bit is valid in the cycle after the din accept.
//   - With i_bit_ready held high, the last bit is at accept+len and o_done at accept+len+1.
//   - din_ready returns at accept+len+2, so back-to-back throughput is len bits per len+2 cycles.
// - Counter: LEN_W bits, never underflows (only decrements in SHIFT with cnt>=1).
// - Bits below the requested length are never emitted; the zeros shifted in from the LSB are never emitted.
// - Outputs are registered state or simple decodes of state/shift_reg; there is no combinational path from i_bit_ready to o_bit_valid or o_bit.
// STRUCTURE
// - Shared package shift_pkg:
//   - state enum {IDLE, SHIFT, DONE} (2-bit encoding)
//   - localparam defaults MSB=16, LEN_W=5
//   - function eff_len()
// - Sub-module shift_reg_en (MSB-wide register with synchronous rst, load, shift-enable and hold) holds the datapath.
// - Top level holds the FSM, bit counter and handshake decode.
// TESTING
// 1. Reset: hold i_rst 2 cycles with din_valid=1 -> din_ready=1, o_bit_valid=0, o_busy=0, o_done=0; nothing accepted.
// 2. Full word: din=16'hA5C3, i_len=0, ready=1 -> bits 1010_0101_1100_0011 on cycles 1..16 after accept; o_done at cycle 17; din_ready at 18.
// 3. Backpressure: din=16'h8001, i_len=16, ready toggling 1,0,0,1,... -> o_bit held while stalled; exactly 16 beats, MSB first; o_done once.
// 4. Short length: din=16'hF000, i_len=3 -> 3 beats of 1; o_done next cycle; len=17 behaves as len 16.
// 5. Flush: i_flush at beat 5 of 16'hFFFF -> IDLE next cycle, o_done never pulses; next word 16'h0001 with len=16 serializes cleanly.
// 6. Reset mid-word: i_rst at beat 8 with i_flush=1 and i_bit_ready=1 -> state IDLE, o_bit=0, o_bit_valid=0; no o_done pulse.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and helpers for the MSB-first shift serializer slice.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int MSB_DEFAULT   = 16;
  localparam int LEN_W_DEFAULT = 5;

  // A zero or oversized length request means "send the whole word".
  function automatic int eff_len(input int len, input int msb);
    return ((len == 0) || (len > msb)) ? msb : len;
  endfunction

endpackage

// File: rtl/shift_reg_en.sv
// Left-shift register with synchronous reset, clear, parallel load and hold.
module shift_reg_en
  import shift_pkg::*;
#(
  parameter int W = MSB_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  // Clear beats load beats shift; with nothing asserted the word holds.
  always_comb begin
    q_d = q_q;
    if (i_clr) begin
      q_d = '0;
    end else if (i_load) begin
      q_d = i_din;
    end else if (i_shift) begin
      q_d = {q_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign o_q = q_q;

endmodule

// File: rtl/shift_serializer_ctrl.sv
// Load/shift sequencer: accepts a parallel word, then streams it MSB-first
// one bit per accepted beat, honouring sink backpressure and flush.
module shift_serializer_ctrl
  import shift_pkg::*;
#(
  parameter int MSB   = MSB_DEFAULT,
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [MSB-1:0]   din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_flush,
  output logic             o_bit,
  output logic             o_bit_valid,
  input  logic             i_bit_ready,
  output logic             o_busy,
  output logic             o_done
);

  state_e           state_q;
  state_e           state_d;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;
  logic [MSB-1:0]   sr_q;
  logic             accept;
  logic             beat;
  logic             sr_clr;
  logic             sr_load;
  logic             sr_shift;

  assign din_ready   = (state_q == IDLE) && !i_flush;
  assign accept      = din_ready && din_valid;
  assign o_bit_valid = (state_q == SHIFT);
  assign beat        = o_bit_valid && i_bit_ready;

  // Flush abandons any word in flight; otherwise the counter tracks bits left.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_clr   = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    if (i_flush && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      sr_clr  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sr_load = 1'b1;
            cnt_d   = LEN_W'(eff_len(32'(i_len), MSB));
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (beat) begin
            sr_shift = 1'b1;
            cnt_d    = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  shift_reg_en #(
    .W(MSB)
  ) u_shift_reg (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (sr_clr),
    .i_load (sr_load),
    .i_shift(sr_shift),
    .i_din  (din),
    .o_q    (sr_q)
  );

  assign o_bit  = sr_q[MSB-1];
  assign o_busy = (state_q == SHIFT) || (state_q == DONE);
  assign o_done = (state_q == DONE) && !i_flush;

endmodule

// File: tb/tb_shift_serializer_ctrl.sv
// Directed bench for shift_serializer_ctrl: a queue-based model checked every
// cycle, plus literal latency/bit-pattern expectations per scenario.
module tb_shift_serializer_ctrl;

  logic        i_clk;
  logic        i_rst;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [4:0]  i_len;
  logic        i_flush;
  logic        o_bit;
  logic        o_bit_valid;
  logic        i_bit_ready;
  logic        o_busy;
  logic        o_done;

  int checks   = 0;
  int failures = 0;

  logic [15:0] cap;
  int          beats;
  int          dones;

  bit mq[$];
  bit m_done;
  bit m_known;

  shift_serializer_ctrl #(
    .MSB  (16),
    .LEN_W(5)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .i_len      (i_len),
    .i_flush    (i_flush),
    .o_bit      (o_bit),
    .o_bit_valid(o_bit_valid),
    .i_bit_ready(i_bit_ready),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic valid, input logic [15:0] word,
                               input logic [4:0] len, input logic flush, input logic ready);
    i_rst       = rst;
    din_valid   = valid;
    din         = word;
    i_len       = len;
    i_flush     = flush;
    i_bit_ready = ready;
  endtask

  // Model: a queue of the bits still owed to the sink, plus a done flag.
  always @(posedge i_clk) begin
    if (i_rst) begin
      mq.delete();
      m_done  = 1'b0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (i_flush) begin
        mq.delete();
        m_done = 1'b0;
      end else if (mq.size() == 0 && !m_done) begin
        if (din_valid) begin
          int n;
          n = (i_len == 0 || i_len > 16) ? 16 : int'(i_len);
          for (int i = 0; i < n; i++) mq.push_back(din[15-i]);
        end
      end else if (mq.size() > 0) begin
        if (i_bit_ready) begin
          void'(mq.pop_front());
          if (mq.size() == 0) m_done = 1'b1;
        end
      end else begin
        m_done = 1'b0;
      end
    end
  end

  always @(negedge i_clk) begin
    if (m_known) begin
      bit idle;
      idle = (mq.size() == 0) && !m_done;
      checkOutput("din_ready", 32'(din_ready), 32'(idle && !i_flush));
      checkOutput("o_bit_valid", 32'(o_bit_valid), 32'(mq.size() > 0));
      checkOutput("o_busy", 32'(o_busy), 32'(!idle));
      checkOutput("o_done", 32'(o_done), 32'(m_done && !i_flush));
      if (mq.size() > 0) checkOutput("o_bit", 32'(o_bit), 32'(mq[0]));
    end
    if (o_bit_valid && i_bit_ready) begin
      cap = {cap[14:0], o_bit};
      beats++;
    end
    if (o_done) dones++;
  end

  // Accepts one word, then drives ready/flush/reset per cycle k after accept.
  task automatic runWord(input logic [15:0] w, input logic [4:0] l, input int mode,
                         input int flush_k, input int rst_k, input int max_k,
                         output int done_k, output int ready_k);
    cap    = '0;
    beats  = 0;
    dones  = 0;
    done_k = 0;
    ready_k = 0;
    applyStimulus(1'b0, 1'b1, w, l, 1'b0, 1'b1);
    @(posedge i_clk);
    #1;
    din_valid = 1'b0;
    for (int k = 1; k <= max_k; k++) begin
      i_bit_ready = (mode == 0) ? 1'b1 : (((k - 1) % 3) == 0);
      i_flush     = (k == flush_k);
      i_rst       = (k == rst_k);
      @(negedge i_clk);
      if (o_done && done_k == 0) done_k = k;
      if (din_ready && ready_k == 0) ready_k = k;
      @(posedge i_clk);
      #1;
      if (ready_k != 0) break;
    end
    i_flush     = 1'b0;
    i_rst       = 1'b0;
    i_bit_ready = 1'b0;
  endtask

  initial begin
    int dk;
    int rk;
    m_known = 1'b0;
    m_done  = 1'b0;
    cap     = '0;
    beats   = 0;
    dones   = 0;

    // Reset held with a pending word: nothing may be accepted.
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 5'd0, 1'b0, 1'b1);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("rst_din_ready", 32'(din_ready), 32'd1);
    checkOutput("rst_bit_valid", 32'(o_bit_valid), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_done", 32'(o_done), 32'd0);
    checkOutput("rst_bit", 32'(o_bit), 32'd0);
    @(posedge i_clk);
    #1;
    applyStimulus(1'b0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
    @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("post_rst_busy", 32'(o_busy), 32'd0);
    @(posedge i_clk);
    #1;

    runWord(16'hA5C3, 5'd0, 0, 0, 0, 40, dk, rk);
    checkOutput("full_bits", 32'(cap), 32'h0000A5C3);
    checkOutput("full_beats", 32'(beats), 32'd16);
    checkOutput("full_done_k", 32'(dk), 32'd17);
    checkOutput("full_ready_k", 32'(rk), 32'd18);

    runWord(16'h8001, 5'd16, 1, 0, 0, 80, dk, rk);
    checkOutput("bp_bits", 32'(cap), 32'h00008001);
    checkOutput("bp_beats", 32'(beats), 32'd16);
    checkOutput("bp_dones", 32'(dones), 32'd1);
    checkOutput("bp_done_k", 32'(dk), 32'd47);

    runWord(16'hF000, 5'd3, 0, 0, 0, 20, dk, rk);
    checkOutput("short_bits", 32'(cap), 32'h00000007);
    checkOutput("short_beats", 32'(beats), 32'd3);
    checkOutput("short_done_k", 32'(dk), 32'd4);
    checkOutput("short_ready_k", 32'(rk), 32'd5);

    runWord(16'h8001, 5'd17, 0, 0, 0, 40, dk, rk);
    checkOutput("len17_bits", 32'(cap), 32'h00008001);
    checkOutput("len17_beats", 32'(beats), 32'd16);
    checkOutput("len17_done_k", 32'(dk), 32'd17);

    runWord(16'hFFFF, 5'd16, 0, 5, 0, 40, dk, rk);
    checkOutput("flush_beats", 32'(beats), 32'd5);
    checkOutput("flush_dones", 32'(dones), 32'd0);
    checkOutput("flush_ready_k", 32'(rk), 32'd6);

    runWord(16'h0001, 5'd16, 0, 0, 0, 40, dk, rk);
    checkOutput("after_flush_bits", 32'(cap), 32'h00000001);
    checkOutput("after_flush_done_k", 32'(dk), 32'd17);

    runWord(16'hFFFF, 5'd0, 0, 8, 8, 40, dk, rk);
    checkOutput("rst_mid_beats", 32'(beats), 32'd8);
    checkOutput("rst_mid_dones", 32'(dones), 32'd0);
    checkOutput("rst_mid_ready_k", 32'(rk), 32'd9);
    @(negedge i_clk);
    checkOutput("rst_mid_bit", 32'(o_bit), 32'd0);
    checkOutput("rst_mid_valid", 32'(o_bit_valid), 32'd0);

    repeat (2) @(posedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
